// File: rtl/code_sender.sv
// -----------------------------------------------------------------------------
// code_sender
//
// Serial code transmitter for the two-wire one-hot symbol interface of the
// digital lock. A start request plays out the stored code MSB first, one
// single-cycle pulse per symbol on bit0 (symbol 0) or bit1 (symbol 1), with
// GAP idle cycles between symbols, followed by a one-cycle done pulse.
//
// Optional feature: define CODE_SENDER_PARITY_EN to append one even-parity
// symbol (XOR of all code register bits) after the last code symbol.
//
// Parameters
//   CODE_LEN      number of code symbols (>= 1)
//   GAP           idle cycles between consecutive symbols (0 allowed)
//   DEFAULT_CODE  code register value after reset
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   start      in   request one transmission (sampled only while busy = 0)
//   code_load  in   load code_in into the code register (only while busy = 0)
//   code_in    in   new code value, bit CODE_LEN-1 is sent first
//   bit0       out  one-cycle pulse = symbol 0
//   bit1       out  one-cycle pulse = symbol 1
//   busy       out  transmission in progress
//   done       out  one-cycle pulse after the final symbol
//   state_o    out  current FSM state (debug)
//
// Handshake: start and code_load are single-cycle requests with no ready
// signal; they take effect only on an edge where busy is low, otherwise they
// are dropped (never queued). All outputs are registered.
// -----------------------------------------------------------------------------
module code_sender #(
   parameter int                  CODE_LEN     = 6,
   parameter int                  GAP          = 2,
   parameter logic [CODE_LEN-1:0] DEFAULT_CODE = CODE_LEN'(6'b011001)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic                code_load,
   input  logic [CODE_LEN-1:0] code_in,
   output logic                bit0,
   output logic                bit1,
   output logic                busy,
   output logic                done,
   output logic [1:0]          state_o
);

`ifdef CODE_SENDER_PARITY_EN
   localparam int PAR_OFS = 1;
`else
   localparam int PAR_OFS = 0;
`endif

   // Total symbols per transmission; the parity slot (if any) is index 0.
   localparam int NUM_SYM = CODE_LEN + PAR_OFS;
   localparam int IW      = $clog2(CODE_LEN + 1);
   localparam int GW      = (GAP > 0) ? $clog2(GAP + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [IW-1:0]       sym_q, sym_d;   // symbol index, counts down to 0
   logic [GW-1:0]       gap_q, gap_d;   // remaining gap cycles
   logic [CODE_LEN-1:0] code_q, code_d;
   logic                bit0_q, bit0_d;
   logic                bit1_q, bit1_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [CODE_LEN-1:0] code_eff;
   logic                sym_val;

   // A load on the same edge as start must already feed the first symbol,
   // so the symbol lookup uses the value the register is about to take.
   always_comb begin
      code_eff = code_q;
      if (code_load && !busy_q) begin
         code_eff = code_in;
      end
      code_d = code_eff;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      sym_d   = sym_q;
      gap_d   = gap_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_SEND;
               sym_d   = IW'(NUM_SYM - 1);
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SEND: begin
            if (sym_q == '0) begin
               state_d = S_DONE;
            end else begin
               sym_d = sym_q - IW'(1);
               if (GAP > 0) begin
                  state_d = S_GAP;
                  gap_d   = GW'(GAP);
               end
            end
         end
         S_GAP: begin
            if (gap_q == GW'(1)) begin
               state_d = S_SEND;
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Value of the symbol that will be on the wire next cycle.
   always_comb begin
      sym_val = 1'b0;
      for (int i = 0; i < CODE_LEN; i++) begin
         if (sym_d == IW'(i + PAR_OFS)) begin
            sym_val = code_eff[i];
         end
      end
      if ((PAR_OFS == 1) && (sym_d == '0)) begin
         sym_val = ^code_eff;
      end
   end

   // Outputs are registered copies of the decoded next state.
   always_comb begin
      bit0_d = (state_d == S_SEND) && !sym_val;
      bit1_d = (state_d == S_SEND) &&  sym_val;
      busy_d = (state_d == S_SEND) || (state_d == S_GAP);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         sym_q   <= '0;
         gap_q   <= '0;
         code_q  <= DEFAULT_CODE;
         bit0_q  <= 1'b0;
         bit1_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sym_q   <= sym_d;
         gap_q   <= gap_d;
         code_q  <= code_d;
         bit0_q  <= bit0_d;
         bit1_q  <= bit1_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bit0    = bit0_q;
   assign bit1    = bit1_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_code_sender.sv
// -----------------------------------------------------------------------------
// tb_code_sender
//
// Two instances share one stimulus stream: dut_a with default parameters
// (GAP = 2) and dut_b with GAP = 0 and a different reset code. A reference
// model derives each expected output from the transmission's start edge and
// the timing formulas: symbol k at offset k*(GAP+1), busy over the whole
// symbol span, done one cycle after the final symbol.
// -----------------------------------------------------------------------------
module tb_code_sender;
   localparam int L = 6;
`ifdef CODE_SENDER_PARITY_EN
   localparam int S = L + 1;
`else
   localparam int S = L;
`endif

   logic         clock = 1'b0;
   logic         reset;
   logic         start;
   logic         code_load;
   logic [L-1:0] code_in;
   logic         b0_a, b1_a, busy_a, done_a;
   logic         b0_b, b1_b, busy_b, done_b;
   logic [1:0]   st_a, st_b;

   // clock / reset block
   always #5 clock = ~clock;

   code_sender #(.CODE_LEN(L), .GAP(2), .DEFAULT_CODE(6'b011001)) dut_a (
      .clock(clock), .reset(reset), .start(start), .code_load(code_load),
      .code_in(code_in), .bit0(b0_a), .bit1(b1_a), .busy(busy_a),
      .done(done_a), .state_o(st_a)
   );

   code_sender #(.CODE_LEN(L), .GAP(0), .DEFAULT_CODE(6'b110100)) dut_b (
      .clock(clock), .reset(reset), .start(start), .code_load(code_load),
      .code_in(code_in), .bit0(b0_b), .bit1(b1_b), .busy(busy_b),
      .done(done_b), .state_o(st_b)
   );

   // reference model state, one entry per instance
   int           gap_m[2] = '{2, 0};
   logic [L-1:0] def_m[2] = '{6'b011001, 6'b110100};
   logic [L-1:0] code_m[2];
   logic [L-1:0] snap[2];
   bit           active[2] = '{0, 0};
   int           t0[2] = '{0, 0};

   int total = 0;
   int bad   = 0;
   int e     = 0;   // edges elapsed

   // Expected {bit0, bit1, busy, done} for the current cycle.
   function automatic logic [3:0] exp_out(int i);
      logic [3:0]   r;
      logic [L-1:0] sh;
      int off, per, last, k;
      logic v;
      r = 4'b0000;
      if (active[i]) begin
         per  = gap_m[i] + 1;
         last = (S - 1) * per;
         off  = e - t0[i];
         if (off >= 0 && off <= last) begin
            r[1] = 1'b1;
            if (off % per == 0) begin
               k = off / per;
               if (k >= L) begin
                  v = ^snap[i];
               end else begin
                  sh = snap[i] >> (L - 1 - k);
                  v  = sh[0];
               end
               r[3] = ~v;
               r[2] = v;
            end
         end
         if (off == last + 1) r[0] = 1'b1;
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s edge=%0d got(b0,b1,busy,done)=%b want=%b", tag, e, obs, expv);
      end
   endtask

   // driver: apply inputs for one edge, advance the model, check outputs
   task automatic step(input logic st, input logic ld, input logic [L-1:0] ci, input logic rs);
      logic [3:0] cur;
      start     = st;
      code_load = ld;
      code_in   = ci;
      reset     = rs;
      for (int i = 0; i < 2; i++) begin
         cur = exp_out(i);
         if (rs) begin
            code_m[i] = def_m[i];
            active[i] = 1'b0;
         end else begin
            if (ld && !cur[1]) code_m[i] = ci;
            if (st && !cur[1]) begin
               active[i] = 1'b1;
               t0[i]     = e + 1;
               snap[i]   = code_m[i];
            end
         end
      end
      @(posedge clock);
      e++;
      @(negedge clock);
      check("inst_a", {b0_a, b1_a, busy_a, done_a}, exp_out(0));
      check("inst_b", {b0_b, b1_b, busy_b, done_b}, exp_out(1));
   endtask

   task automatic idle(input int n);
      for (int j = 0; j < n; j++) step(1'b0, 1'b0, '0, 1'b0);
   endtask

   initial begin
      logic hold;
      logic st, ld, rs;
      reset     = 1'b1;
      start     = 1'b0;
      code_load = 1'b0;
      code_in   = '0;
      hold      = 1'b0;
      @(negedge clock);
      repeat (3) step(1'b0, 1'b0, '0, 1'b1);

      // default code
      step(1'b1, 1'b0, '0, 1'b0);
      idle(22);

      // load together with start, then reuse the loaded code
      step(1'b1, 1'b1, 6'b101010, 1'b0);
      idle(21);
      step(1'b1, 1'b0, '0, 1'b0);
      idle(21);

      // start and load mid-transmission are ignored
      step(1'b1, 1'b0, '0, 1'b0);
      idle(4);
      step(1'b1, 1'b1, 6'b111111, 1'b0);
      idle(20);
      step(1'b1, 1'b0, '0, 1'b0);
      idle(21);

      // reset mid-transmission, then resend the default code
      step(1'b1, 1'b0, '0, 1'b0);
      idle(7);
      step(1'b0, 1'b0, '0, 1'b1);
      idle(3);
      step(1'b1, 1'b0, '0, 1'b0);
      idle(21);

      // start held high: back-to-back transmissions
      for (int j = 0; j < 60; j++) step(1'b1, 1'b0, '0, 1'b0);
      idle(21);

      // randomized traffic
      for (int j = 0; j < 3000; j++) begin
         if ($urandom_range(0, 49) == 0) hold = ~hold;
         st = hold ? 1'b1 : ($urandom_range(0, 5) == 0);
         ld = ($urandom_range(0, 7) == 0);
         rs = ($urandom_range(0, 299) == 0);
         step(st, ld, L'($urandom_range(0, (1 << L) - 1)), rs);
      end
      idle(25);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
